// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared state type and reset defaults for the clock-enable scheduler
package clk_sched_pkg;

  // IDLE: parked, ARM: one-cycle counter clear, RUN: strobing, DRAIN: finishing the last period
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

  // Divide ratio and DAC strobe offset in force after reset
  localparam int RST_DIV_DEF   = 2;
  localparam int RST_PHASE_DEF = 1;

  // Smallest ratio that still leaves room for two distinct strobe slots
  localparam int MIN_DIV       = 2;

endpackage

// File: rtl/clk_en_scheduler_phase_counter.sv
// rtl/clk_en_scheduler_phase_counter.sv - modulo-N period counter with clear, enable and wrap flag
module phase_counter #(
  parameter int DIV_W = 8
) (
  input  logic             Pll_CLK,
  input  logic             RESETn,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic             wrap
);

  // Last slot of the period; the caller qualifies it with its own enable
  assign wrap = (cnt == (div - DIV_W'(1)));

  // Count 0..div-1 while enabled, clear overrides counting
  always_ff @(posedge Pll_CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_en_scheduler.sv
// rtl/clk_en_scheduler.sv - function-generator / DAC clock-enable scheduler with safe reconfiguration
module clk_en_scheduler
  import clk_sched_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int RST_DIV   = RST_DIV_DEF,
  parameter int RST_PHASE = RST_PHASE_DEF
) (
  input  logic             Pll_CLK,
  input  logic             RESETn,
  input  logic             run,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             fg_ce,
  output logic             dac_ce,
  output logic             busy
);

  sched_state_t     state;
  sched_state_t     state_nxt;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_n;
  logic [DIV_W-1:0] phase_p;
  logic [DIV_W-1:0] shadow_div;
  logic [DIV_W-1:0] shadow_phase;
  logic             pend;
  logic             wrap;
  logic             active;
  logic             period_end;
  logic             req_take;
  logic             req_valid;
  logic             apply_pend;
  logic             ack_q;
  logic             err_q;

  phase_counter #(
    .DIV_W (DIV_W)
  ) u_phase_counter (
    .Pll_CLK (Pll_CLK),
    .RESETn  (RESETn),
    .clr     (!active),
    .en      (active),
    .div     (div_n),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  // Request qualification and the points where a parked request may take effect:
  // whenever no period is running, or exactly on the wrap edge of a running period
  always_comb begin
    active     = (state == ST_RUN) || (state == ST_DRAIN);
    period_end = active && wrap;
    req_take   = cfg_req && !pend;
    req_valid  = (cfg_div >= DIV_W'(MIN_DIV)) && (cfg_phase < cfg_div);
    apply_pend = pend && (!active || period_end);
  end

  // State register
  always_ff @(posedge Pll_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobe decode; strobes come only from state/cnt/phase registers
  always_comb begin
    state_nxt = state;
    fg_ce     = 1'b0;
    dac_ce    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) begin
          state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        fg_ce  = (cnt == '0);
        dac_ce = (cnt == phase_p);
        if (!run) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        fg_ce  = (cnt == '0);
        dac_ce = (cnt == phase_p);
        if (run) begin
          state_nxt = ST_RUN;
        end else if (wrap) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Configuration handling: reject, apply immediately when idle, or park in the
  // shadow until the running period wraps so no period is cut short or stretched
  always_ff @(posedge Pll_CLK or negedge RESETn) begin
    if (!RESETn) begin
      div_n        <= DIV_W'(RST_DIV);
      phase_p      <= DIV_W'(RST_PHASE);
      shadow_div   <= '0;
      shadow_phase <= '0;
      pend         <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (apply_pend) begin
        div_n   <= shadow_div;
        phase_p <= shadow_phase;
        pend    <= 1'b0;
        ack_q   <= 1'b1;
        err_q   <= 1'b0;
      end else if (req_take) begin
        if (!req_valid) begin
          ack_q <= 1'b1;
          err_q <= 1'b1;
        end else if (!active) begin
          div_n   <= cfg_div;
          phase_p <= cfg_phase;
          ack_q   <= 1'b1;
          err_q   <= 1'b0;
        end else begin
          pend         <= 1'b1;
          shadow_div   <= cfg_div;
          shadow_phase <= cfg_phase;
        end
      end
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

endmodule
